// File: rtl/dahb_master_param.sv
// dahb_master_param: single-outstanding AHB master draining a request FIFO.
// Define DAHB_LOAD_BYPASS_EN for the low-latency request path (IDLE->ADDR on an immediate grant).
module dahb_master_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HBUSREQ,
  output logic              HLOCK,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              wr_err,
  output logic [PTR_W:0]    pend_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} state_t;
  typedef struct packed {
    logic [2:0]        size;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } entry_t;
  state_t state, state_nx;
  entry_t mem [DEPTH];
  entry_t head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop, done, ok, byp, go;
  assign head      = mem[rd_ptr];
  assign req_ready = pend_cnt != (PTR_W+1)'(DEPTH);
  assign push      = req_valid && req_ready;
  assign done      = state == DATA && HREADY;
  assign ok        = !HRESP[1];
  assign pop       = done && ok;
`ifdef DAHB_LOAD_BYPASS_EN
  assign byp = HRESETn && state == IDLE && pend_cnt == '0 && req_valid;
`else
  assign byp = 1'b0;
`endif
  assign go = byp && HGRANT && HREADY;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = go ? ADDR : (pend_cnt != '0 || push) ? REQ : IDLE;
      REQ:  state_nx = (HGRANT && HREADY) ? ADDR : REQ;
      ADDR: state_nx = HREADY ? DATA : ADDR;
      DATA: state_nx = HREADY ? (ok ? IDLE : REQ) : DATA;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_cnt <= '0;
      HWDATA   <= '0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr + PTR_W'(push);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      pend_cnt <= pend_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (state == ADDR && HREADY) HWDATA <= head.wdata;
    end
  end
  always_ff @(posedge HCLK)
    if (push) mem[wr_ptr] <= {req_size, req_write, req_wdata, req_addr};
  assign HBUSREQ  = state == REQ || byp;
  assign HLOCK    = 1'b0;
  assign HBURST   = 3'b000;
  assign HPROT    = 4'b0011;
  assign HTRANS   = state == ADDR ? 2'b10 : 2'b00;
  assign HADDR    = state == ADDR ? head.addr : '0;
  assign HWRITE   = state == ADDR && head.write;
  assign HSIZE    = state == ADDR ? head.size : 3'b000;
  assign rd_data  = HRDATA;
  assign rd_valid = pop && !head.write;
  assign rd_err   = rd_valid && HRESP == 2'b01;
  assign wr_err   = pop && head.write && HRESP == 2'b01;
endmodule

// File: tb/tb_dahb_master_param.sv
// tb_dahb_master_param: directed stimulus with a scoreboard queue checked by an independent bus monitor.
module tb_dahb_master_param;
`ifdef DAHB_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        HCLK = 1'b0, HRESETn = 1'b0, HGRANT = 1'b0, HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
  logic [31:0] HRDATA = '0;
  logic        HBUSREQ, HLOCK, HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rd_valid, rd_err, wr_err;
  logic [31:0] rd_data;
  logic [3:0]  pend_cnt;

  dahb_master_param dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HGRANT(HGRANT), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .wr_err(wr_err), .pend_cnt(pend_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, passed = 0;
  logic in_data = 1'b0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  // Bus-side monitor: tracks the data phase from observed NONSEQ + HREADY and scores completions.
  always @(negedge HCLK) begin
    if (!HRESETn) in_data <= 1'b0;
    else begin
      if (in_data && HREADY && !HRESP[1]) begin
        if (sb.size() == 0) chk("completion with empty scoreboard", sb.size(), 1);
        else begin
          e = sb.pop_front();
          if (e.w) begin
            chk("HWDATA", HWDATA, e.d);
            chk("wr_err", wr_err, e.err);
            chk("rd_valid on write", rd_valid, 0);
          end else begin
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, e.d);
            chk("rd_err", rd_err, e.err);
            chk("wr_err on read", wr_err, 0);
          end
        end
      end else if (rd_valid || wr_err) chk("spurious pulse", {rd_valid, wr_err}, 2'b00);
      if (HTRANS == 2'b10) begin
        chk("overlapping transfer", in_data, 0);
        if (sb.size() == 0) chk("issue with empty scoreboard", sb.size(), 1);
        else begin
          chk("HADDR", HADDR, sb[0].a);
          chk("HWRITE", HWRITE, sb[0].w);
          chk("HSIZE", HSIZE, sb[0].sz);
        end
      end
      in_data <= (in_data && !HREADY) || (HTRANS == 2'b10 && HREADY);
    end
  end

  task automatic send(input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic err);
    exp_t x;
    x.w = w; x.sz = sz; x.a = a; x.d = exp_d; x.err = err;
    sb.push_back(x);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge HCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string n);
    int k = 0;
    while ((sb.size() != 0 || pend_cnt != 0) && k < 200) begin
      @(posedge HCLK); #1;
      k++;
    end
    chk(n, k < 200, 1);
  endtask

  task automatic wait_nonseq(input string n);
    int k = 0;
    do begin
      @(negedge HCLK);
      k++;
    end while (HTRANS != 2'b10 && k < 50);
    chk(n, HTRANS, 2'b10);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset bus outputs", {HBUSREQ, HTRANS, HADDR, HWRITE, HSIZE, HWDATA}, '0);
    chk("reset pulses", {rd_valid, rd_err, wr_err}, 3'b000);
    chk("reset req_ready", req_ready, 1);
    chk("reset pend_cnt", pend_cnt, 0);
    chk("tied outputs", {HLOCK, HBURST, HPROT}, {1'b0, 3'b000, 4'b0011});
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Single read latency
    HGRANT = 1'b1; HRDATA = 32'hDEADBEEF;
    sb.push_back('{w: 1'b0, sz: 3'd2, a: 32'h1000, d: 32'hDEADBEEF, err: 1'b0});
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'd2; req_addr = 32'h1000; req_wdata = '0;
    #3 chk("HBUSREQ cycle0", HBUSREQ, BYP);
    @(posedge HCLK); #1 req_valid = 1'b0;
    #3 chk("HTRANS cycle1", HTRANS, BYP ? 2'b10 : 2'b00);
    chk("HBUSREQ cycle1", HBUSREQ, !BYP);
    @(posedge HCLK); #4 chk("HTRANS cycle2", HTRANS, BYP ? 2'b00 : 2'b10);
    chk("rd_valid cycle2", rd_valid, BYP);
    @(posedge HCLK); #4 chk("rd_valid cycle3", rd_valid, !BYP);
    @(posedge HCLK); #1;
    drain("single read drain");

    // Fill the buffer without grant, then drain in order
    HGRANT = 1'b0;
    for (int i = 0; i < 8; i++)
      send(1'b1, 3'(i % 3), 32'h100 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 32'h11111111 * 32'(i + 1), 1'b0);
    chk("full pend_cnt", pend_cnt, 8);
    chk("full req_ready", req_ready, 0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'd2; req_addr = 32'h999; req_wdata = 32'hBAD;
    @(posedge HCLK); #1 req_valid = 1'b0;
    chk("ninth push ignored", pend_cnt, 8);
    HGRANT = 1'b1;
    drain("eight writes drain");
    chk("req_ready after drain", req_ready, 1);

    // Write then read of the same address
    HRDATA = 32'h55AA55AA;
    send(1'b1, 3'd2, 32'h2004, 32'h55AA55AA, 32'h55AA55AA, 1'b0);
    send(1'b0, 3'd1, 32'h2004, 32'h0, 32'h55AA55AA, 1'b0);
    drain("write-read drain");

    // Two-cycle RETRY: same address reissued, one completion
    HGRANT = 1'b0; HRDATA = 32'hCAFEF00D;
    send(1'b0, 3'd2, 32'h3000, 32'h0, 32'hCAFEF00D, 1'b0);
    chk("retry pend before", pend_cnt, 1);
    HGRANT = 1'b1;
    wait_nonseq("retry first issue");
    @(posedge HCLK); #1 HREADY = 1'b0; HRESP = 2'b10;
    #3 chk("retry cycle1 rd_valid", rd_valid, 0);
    @(posedge HCLK); #1 HREADY = 1'b1;
    #3 chk("retry cycle2 rd_valid", rd_valid, 0);
    chk("retry no pop", pend_cnt, 1);
    @(posedge HCLK); #1 HRESP = 2'b00;
    #3 chk("retry HBUSREQ", HBUSREQ, 1);
    drain("retry drain");

    // Two-cycle ERROR on a write, next entry proceeds
    HGRANT = 1'b0;
    send(1'b1, 3'd2, 32'h4000, 32'h11, 32'h11, 1'b1);
    send(1'b1, 3'd0, 32'h4004, 32'h22, 32'h22, 1'b0);
    HGRANT = 1'b1;
    wait_nonseq("error first issue");
    @(posedge HCLK); #1 HREADY = 1'b0; HRESP = 2'b01;
    #3 chk("error cycle1 wr_err", wr_err, 0);
    chk("error cycle1 pend", pend_cnt, 2);
    @(posedge HCLK); #1 HREADY = 1'b1;
    #3 chk("error cycle2 wr_err", wr_err, 1);
    @(posedge HCLK); #1 HRESP = 2'b00;
    #3 chk("error popped", pend_cnt, 1);
    drain("error drain");

    // Reset during a data phase with three entries buffered
    HGRANT = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b0, 3'd2, 32'h5000 + 32'(4 * i), 32'hAAAA0000 + 32'(i), 32'h0, 1'b0);
    HGRANT = 1'b1;
    wait_nonseq("reset-test issue");
    @(posedge HCLK); #1 HREADY = 1'b0;
    chk("HWDATA before reset", HWDATA, 32'hAAAA0000);
    #1 HRESETn = 1'b0;
    sb.delete();
    #1 chk("mid reset bus outputs", {HBUSREQ, HTRANS, HADDR, HWRITE, HSIZE, HWDATA}, '0);
    chk("mid reset pulses", {rd_valid, rd_err, wr_err}, 3'b000);
    chk("mid reset pend_cnt", pend_cnt, 0);
    chk("mid reset req_ready", req_ready, 1);
    repeat (2) @(posedge HCLK);
    #1 HREADY = 1'b1; HRESETn = 1'b1;
    repeat (5) @(posedge HCLK);
    #1 chk("post reset idle", {HBUSREQ, HTRANS, pend_cnt}, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
